// File: rtl/mul_pkg.sv
// Shared definitions for the multiply sequencer: op codes, FSM states and default sizing.
package mul_pkg;

    localparam int unsigned DEF_WIDTH          = 32;
    localparam int unsigned DEF_BITS_PER_CYCLE = 2;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b10;
    localparam logic [1:0] OP_SMULL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        WB_LO,
        WB_HI,
        DONE
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add_core.sv
// Iterative shift-add datapath: unsigned magnitude product accumulated a few multiplier bits per step,
// with an optional final two's-complement negate.
module mul_shift_add_core #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 fix,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    input  logic                 neg,
    output logic [2*WIDTH-1:0]   acc,
    output logic [2*WIDTH-1:0]   acc_fixed_c,
    output logic                 last_step_c
);

    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
        $error("mul_shift_add_core: BITS_PER_CYCLE must divide WIDTH");
    end

    // a_sh carries the multiplicand pre-shifted to the current iteration's weight
    logic [ACC_W-1:0] a_sh;
    logic [WIDTH-1:0] b_shift;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic [ACC_W-1:0] partial_c;

    assign partial_c   = a_sh * ACC_W'(b_shift[BITS_PER_CYCLE-1:0]);
    assign acc_fixed_c = neg_q ? (~acc + ACC_W'(1)) : acc;
    assign last_step_c = (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            a_sh    <= '0;
            b_shift <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
        end else if (load) begin
            acc     <= '0;
            a_sh    <= ACC_W'(a_mag);
            b_shift <= b_mag;
            cnt     <= CNT_W'(STEPS - 1);
            neg_q   <= neg;
        end else if (step) begin
            acc     <= acc + partial_c;
            a_sh    <= a_sh << BITS_PER_CYCLE;
            b_shift <= b_shift >> BITS_PER_CYCLE;
            cnt     <= cnt - CNT_W'(1);
        end else if (fix) begin
            acc     <= acc_fixed_c;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// MUL/UMULL/SMULL sequencer: stalls the core, runs the shift-add core, then writes the result back.
// Optional MUL_SEQ_DUAL_WB_EN adds a second write port so long ops write RdLo/RdHi in one cycle.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       wa_lo,
    input  logic [3:0]       wa_hi,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    output logic [3:0]       wr_addr,
    output logic [WIDTH-1:0] wr_data,
`ifdef MUL_SEQ_DUAL_WB_EN
    output logic             wr_en2,
    output logic [3:0]       wr_addr2,
    output logic [WIDTH-1:0] wr_data2,
`endif
    output logic             flag_n,
    output logic             flag_z
);

    localparam int unsigned ACC_W = 2 * WIDTH;
`ifdef MUL_SEQ_DUAL_WB_EN
    localparam bit DUAL_WB = 1'b1;
`else
    localparam bit DUAL_WB = 1'b0;
`endif

    mul_state_e       state, state_next;
    logic             is_long_q;
    logic [3:0]       wa_lo_q, wa_hi_q;
    logic             pend_n, pend_z;
    logic             load_c, step_c, fix_c;
    logic             is_long_c, is_signed_c, neg_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [ACC_W-1:0] acc, acc_fixed_c;
    logic             last_step_c;
    logic             busy_d, done_d, wr_en_d, flag_n_d, flag_z_d;
    logic [3:0]       wr_addr_d;
    logic [WIDTH-1:0] wr_data_d;
`ifdef MUL_SEQ_DUAL_WB_EN
    logic             wr_en2_d;
    logic [3:0]       wr_addr2_d;
    logic [WIDTH-1:0] wr_data2_d;
`endif

    // Reserved op 01 falls through as a plain MUL
    assign is_long_c   = (op == OP_UMULL) || (op == OP_SMULL);
    assign is_signed_c = (op == OP_SMULL);
    assign a_mag_c     = (is_signed_c && src_a[WIDTH-1]) ? (~src_a + WIDTH'(1)) : src_a;
    assign b_mag_c     = (is_signed_c && src_b[WIDTH-1]) ? (~src_b + WIDTH'(1)) : src_b;
    assign neg_c       = is_signed_c && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);

    mul_shift_add_core #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load_c),
        .step        (step_c),
        .fix         (fix_c),
        .a_mag       (a_mag_c),
        .b_mag       (b_mag_c),
        .neg         (neg_c),
        .acc         (acc),
        .acc_fixed_c (acc_fixed_c),
        .last_step_c (last_step_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        fix_c      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step_c = 1'b1;
                if (last_step_c) state_next = FIX;
            end
            FIX: begin
                fix_c      = 1'b1;
                state_next = WB_LO;
            end
            WB_LO:   state_next = (is_long_q && !DUAL_WB) ? WB_HI : DONE;
            WB_HI:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered
        busy_d    = (state_next == CALC) || (state_next == FIX) ||
                    (state_next == WB_LO) || (state_next == WB_HI);
        done_d    = (state_next == DONE);
        wr_en_d   = (state_next == WB_LO) || (state_next == WB_HI);
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        if (state_next == WB_LO) begin
            wr_addr_d = wa_lo_q;
            wr_data_d = acc_fixed_c[WIDTH-1:0];
        end else if (state_next == WB_HI) begin
            wr_addr_d = wa_hi_q;
            wr_data_d = acc[ACC_W-1:WIDTH];
        end
        flag_n_d = done_d ? pend_n : flag_n;
        flag_z_d = done_d ? pend_z : flag_z;
`ifdef MUL_SEQ_DUAL_WB_EN
        wr_en2_d   = (state_next == WB_LO) && is_long_q;
        wr_addr2_d = wr_addr2;
        wr_data2_d = wr_data2;
        if (wr_en2_d) begin
            wr_addr2_d = wa_hi_q;
            wr_data2_d = acc_fixed_c[ACC_W-1:WIDTH];
        end
`endif
    end

    // Op context capture and flag pre-computation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_long_q <= 1'b0;
            wa_lo_q   <= '0;
            wa_hi_q   <= '0;
            pend_n    <= 1'b0;
            pend_z    <= 1'b0;
        end else if (load_c) begin
            is_long_q <= is_long_c;
            wa_lo_q   <= wa_lo;
            wa_hi_q   <= wa_hi;
        end else if (fix_c) begin
            pend_n    <= is_long_q ? acc_fixed_c[ACC_W-1] : acc_fixed_c[WIDTH-1];
            pend_z    <= is_long_q ? (acc_fixed_c == '0) : (acc_fixed_c[WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            flag_n   <= 1'b0;
            flag_z   <= 1'b0;
`ifdef MUL_SEQ_DUAL_WB_EN
            wr_en2   <= 1'b0;
            wr_addr2 <= '0;
            wr_data2 <= '0;
`endif
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            flag_n   <= flag_n_d;
            flag_z   <= flag_z_d;
`ifdef MUL_SEQ_DUAL_WB_EN
            wr_en2   <= wr_en2_d;
            wr_addr2 <= wr_addr2_d;
            wr_data2 <= wr_data2_d;
`endif
        end
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller and datapath for the MUL, UMULL and SMULL instructions of the multi-cycle ARM core.
- Started by the main control FSM once register operands are read. Computes the product iteratively.
- Drives the register file's single write port: one write for MUL, two sequential writes (RdLo, then RdHi) for long multiplies.
- Holds the main FSM stalled through `busy` and releases it with `done`.

Parameters:
- WIDTH, 32, operand width in bits.
- BITS_PER_CYCLE, 2, multiplier bits consumed per CALC cycle. Must divide WIDTH; a non-divisor is an elaboration error.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the control FSM; sampled only in IDLE.
- op  in  2  00 MUL, 10 UMULL, 11 SMULL; 01 reserved, treated as MUL.
- src_a  in  WIDTH  first operand (Rm), captured on accepted start.
- src_b  in  WIDTH  second operand (Rs), captured on accepted start.
- wa_lo  in  4  destination for MUL Rd / long RdLo, captured on start.
- wa_hi  in  4  long RdHi, captured on start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the final write.
- wr_en  out  1  register-file write enable.
- wr_addr  out  4  register-file write address.
- wr_data  out  WIDTH  register-file write data.
- flag_n  out  1  result negative; valid in the done cycle, held until the next start.
- flag_z  out  1  result zero; valid in the done cycle, held until the next start.

Behaviour:
- Reset:
  - state = IDLE.
  - busy, done, wr_en, flag_n, flag_z = 0.
  - wr_addr = 0, wr_data = 0.
  - All internal registers cleared.
- Reset mid-operation aborts immediately: no write is issued, and the next cycle after release is IDLE.
- IDLE:
  - On start=1, capture op, operands and addresses, then go to CALC.
  - For SMULL, capture operand magnitudes plus a neg flag = sign(a) XOR sign(b).
  - For MUL and UMULL, operands are used as unsigned, neg = 0.
- CALC:
  - Runs exactly WIDTH/BITS_PER_CYCLE cycles (16 at defaults), counted by a down-counter.
  - Each cycle, acc += (a_mag × low BITS_PER_CYCLE bits of b_shift) << (iteration × BITS_PER_CYCLE), and b_shift >>= BITS_PER_CYCLE.
  - acc is 2×WIDTH wide; no truncation before FIX.
- FIX:
  - 1 cycle. If neg, acc = two's-complement negate of acc.
  - Flags computed here: N = acc[2W-1] for long ops or acc[W-1] for MUL; Z = (acc == 0) over the full 64 bits for long ops, low 32 bits for MUL.
  - Flags are latched to the outputs in the done cycle.
- WB_LO: 1 cycle with wr_en=1, wr_addr=wa_lo, wr_data=acc[W-1:0].
- WB_HI: long ops only; 1 cycle with wr_en=1, wr_addr=wa_hi, wr_data=acc[2W-1:W]. MUL skips from WB_LO directly to DONE.
- DONE: 1 cycle with done=1, busy=0, then IDLE.
- wr_en is low in every state other than WB_LO and WB_HI.
- Latency from accepted start to done (defaults): MUL 19 cycles, long 20 cycles.
- start while not IDLE is ignored; no queuing.
- start in the DONE cycle is ignored; the earliest accepted start is the following cycle.
- wa_lo == wa_hi on a long op (architecturally UNPREDICTABLE): both writes are issued; the RdHi value is the final register content.
- Operand changes after the start cycle have no effect.
- A zero operand still runs the full CALC count; there is no early termination.

Optional Feature:
- Macro: MUL_SEQ_DUAL_WB_EN.
- Defined:
  - Adds outputs wr_en2 (1), wr_addr2 (4) and wr_data2 (WIDTH) for the register file's second write port.
  - For long ops, WB_LO drives RdLo on the primary port and RdHi on the second port in the same cycle. WB_HI is never entered, so long latency becomes 19 cycles.
  - wr_en2 is 0 at reset and outside WB_LO.
- Undefined: the extra ports do not exist; sequential single-port writeback as above.

Decomposition:
- Shared package mul_pkg:
  - op encoding localparams (OP_MUL, OP_UMULL, OP_SMULL).
  - FSM state enum (IDLE, CALC, FIX, WB_LO, WB_HI, DONE).
  - Default WIDTH.
- One sub-module, mul_shift_add_core: holds acc, b_shift and the iteration counter, with load/step/negate controls. It reports last_step to the FSM in mul_sequencer.

Test Plan:
- MUL, a=7, b=6, wa_lo=3 -> one write r3=0x0000002A, done 19 cycles after start, N=0, Z=0.
- UMULL, a=b=0xFFFFFFFF, wa_lo=1, wa_hi=2 -> r1=0x00000001 then r2=0xFFFFFFFE on consecutive cycles, N=1, Z=0.
- SMULL, a=0xFFFFFFFE (-2), b=3 -> lo=0xFFFFFFFA, hi=0xFFFFFFFF, N=1. A second SMULL with a=b=0x80000000 -> lo=0x00000000, hi=0x40000000, N=0.
- UMULL with a=0, b=0x12345678 -> both writes 0x00000000, Z=1, full 20-cycle latency.
- start pulse during CALC with different operands -> ignored; result matches first operands. Then assert reset_n=0 mid-CALC of a new op -> no wr_en, busy=0, outputs at reset values.
- With MUL_SEQ_DUAL_WB_EN, UMULL 0x10000 × 0x10000 -> same-cycle wr_data=0x00000000 (port 1) and wr_data2=0x00000001 (port 2), done at 19 cycles.
